// File: rtl/velocity_cell_rmw_pkg.sv
// Shared constants, FSM state type and the fp32 adder function for the velocity
// read-modify-write block.
package velocity_cell_rmw_pkg;

  localparam int FP32_W     = 32;
  localparam int VX_LSB     = 0;
  localparam int VY_LSB     = 32;
  localparam int VZ_LSB     = 64;
  localparam int COUNT_ADDR = 0;

  typedef enum logic [2:0] {
    IDLE, RD_CNT, WAIT_CNT, FETCH, LOAD, ADD, WR, DONE
  } state_t;

  // fp32 add, round-to-nearest-even; denormal inputs read as zero and
  // denormal results flush to +0.
  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, sx, sy, s_res, sticky, round_up, found, is_zero;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [26:0] mx, my, my_sh, mask;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [31:0] res;
    int          ex, ey, d, e_res, lz;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    res = 32'd0;
    if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0)) begin
      res = 32'h7FC00000;
    end else if (ea == 8'hFF && eb == 8'hFF) begin
      res = (sa == sb) ? a : 32'h7FC00000;
    end else if (ea == 8'hFF) begin
      res = a;
    end else if (eb == 8'hFF) begin
      res = b;
    end else if (ea == 8'd0 && eb == 8'd0) begin
      res = {sa & sb, 31'd0};
    end else if (ea == 8'd0) begin
      res = b;
    end else if (eb == 8'd0) begin
      res = a;
    end else begin
      if ({ea, fa} >= {eb, fb}) begin
        sx = sa; ex = int'(ea); mx = {1'b1, fa, 3'b000};
        sy = sb; ey = int'(eb); my = {1'b1, fb, 3'b000};
      end else begin
        sx = sb; ex = int'(eb); mx = {1'b1, fb, 3'b000};
        sy = sa; ey = int'(ea); my = {1'b1, fa, 3'b000};
      end
      d = ex - ey;
      if (d > 26) begin
        my_sh  = 27'd0;
        sticky = 1'b1;
      end else begin
        mask   = ~(27'h7FFFFFF << d);
        sticky = |(my & mask);
        my_sh  = my >> d;
      end
      my_sh[0] = my_sh[0] | sticky;
      e_res    = ex;
      s_res    = sx;
      is_zero  = 1'b0;
      if (sx == sy) begin
        sum = {1'b0, mx} + {1'b0, my_sh};
        if (sum[27]) begin
          sum   = {1'b0, sum[27:2], sum[1] | sum[0]};
          e_res = e_res + 1;
        end
      end else begin
        sum     = {1'b0, mx} - {1'b0, my_sh};
        is_zero = (sum == 28'd0);
        lz      = 0;
        found   = 1'b0;
        for (int i = 26; i >= 0; i--) begin
          if (!found) begin
            if (sum[i]) found = 1'b1;
            else        lz = lz + 1;
          end
        end
        sum   = sum << lz;
        e_res = e_res - lz;
      end
      if (!is_zero) begin
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd      = {1'b0, sum[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
          e_res = e_res + 1;
          rnd   = rnd >> 1;
        end
        if (e_res <= 0)        res = 32'd0;
        else if (e_res >= 255) res = {s_res, 8'hFF, 23'd0};
        else                   res = {s_res, 8'(e_res), rnd[22:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/velocity_cell_rmw_add3.sv
// Three parallel fp32 adders on the {vz,vy,vx} lanes followed by an
// ADD_LATENCY-deep pipeline; the last stage holds its result until replaced.
module velocity_fp_add3
  import velocity_cell_rmw_pkg::*;
#(
  parameter int DATA_WIDTH  = 96,
  parameter int ADD_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] sum_comb;
  logic [DATA_WIDTH-1:0] stage_reg [ADD_LATENCY];
  logic                  vld_reg   [ADD_LATENCY];

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam int LSB = (gi == 0) ? VX_LSB : (gi == 1) ? VY_LSB : VZ_LSB;
    assign sum_comb[LSB +: FP32_W] = fp32_add(a[LSB +: FP32_W], b[LSB +: FP32_W]);
  end

  // Stages advance only behind a valid token so the result stays put while
  // the sequencer waits on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_LATENCY; i++) begin
        stage_reg[i] <= '0;
        vld_reg[i]   <= 1'b0;
      end
    end else begin
      vld_reg[0] <= launch;
      if (launch) stage_reg[0] <= sum_comb;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        if (vld_reg[i-1]) stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign sum = stage_reg[ADD_LATENCY-1];

endmodule

// File: rtl/velocity_cell_rmw.sv
// Per-cell velocity read-modify-write sequencer in front of a 1-cycle RAM.
// Optional stall statistics port enabled by defining VEL_RMW_STALL_STATS_EN.
module velocity_cell_rmw
  import velocity_cell_rmw_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int ADD_LATENCY  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  input  logic                  delta_valid,
  output logic                  delta_ready,
  input  logic [DATA_WIDTH-1:0] delta_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
`ifdef VEL_RMW_STALL_STATS_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  vel_out_valid,
  output logic [ADDR_WIDTH-1:0] vel_out_addr,
  output logic [DATA_WIDTH-1:0] vel_out_data
);

  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam int LAT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  logic [LAT_W-1:0]      lat_reg, lat_next;
  logic [DATA_WIDTH-1:0] delta_reg, delta_next;
  logic                  count_err_reg, count_err_next;
  logic [DATA_WIDTH-1:0] sum;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] count_in;

  assign count_in  = mem_q[ADDR_WIDTH-1:0];
  assign count_err = count_err_reg;

  velocity_fp_add3 #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADD_LATENCY (ADD_LATENCY)
  ) u_add3 (
    .clk    (clk),
    .rst    (rst),
    .launch (launch),
    .a      (mem_q),
    .b      (delta_reg),
    .sum    (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      count_reg     <= '0;
      lat_reg       <= '0;
      delta_reg     <= '0;
      count_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      count_reg     <= count_next;
      lat_reg       <= lat_next;
      delta_reg     <= delta_next;
      count_err_reg <= count_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    count_next     = count_reg;
    lat_next       = lat_reg;
    delta_next     = delta_reg;
    count_err_next = count_err_reg;
    busy           = 1'b0;
    done           = 1'b0;
    delta_ready    = 1'b0;
    mem_address    = '0;
    mem_data       = '0;
    mem_rden       = 1'b0;
    mem_wren       = 1'b0;
    launch         = 1'b0;
    vel_out_valid  = 1'b0;
    vel_out_addr   = '0;
    vel_out_data   = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = RD_CNT;
          count_err_next = 1'b0;
        end
      end
      RD_CNT: begin
        busy        = 1'b1;
        mem_address = ADDR_WIDTH'(COUNT_ADDR);
        mem_rden    = 1'b1;
        state_next  = WAIT_CNT;
      end
      WAIT_CNT: begin
        busy = 1'b1;
        if (count_in > MAX_IDX) begin
          count_next     = MAX_IDX;
          count_err_next = 1'b1;
        end else begin
          count_next = count_in;
        end
        if (count_in == '0) begin
          state_next = DONE;
        end else begin
          idx_next   = ADDR_WIDTH'(1);
          state_next = FETCH;
        end
      end
      FETCH: begin
        busy        = 1'b1;
        delta_ready = 1'b1;
        if (delta_valid) begin
          delta_next  = delta_data;
          mem_address = idx_reg;
          mem_rden    = 1'b1;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        launch     = 1'b1;
        lat_next   = LAT_W'(ADD_LATENCY - 1);
        state_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (lat_reg == '0) state_next = WR;
        else               lat_next   = lat_reg - 1'b1;
      end
      WR: begin
        // A reset in this cycle must not commit the write.
        busy          = 1'b1;
        mem_address   = idx_reg;
        mem_data      = sum;
        mem_wren      = ~rst;
        vel_out_valid = ~rst;
        vel_out_addr  = idx_reg;
        vel_out_data  = sum;
        if (idx_reg == count_reg) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef VEL_RMW_STALL_STATS_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      stall_reg <= '0;
    end else if (state_reg == FETCH && !delta_valid && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`endif

endmodule
